// File: rtl/bit_unstuff_rx_pkg.sv
// Shared USB receive package: FSM state encoding and the default stuffing
// run length used by the bit unstuffer.
// Optional feature macro: BIT_UNSTUFF_ERR_EN (adds the DRAIN state).
package bit_unstuff_rx_pkg;

    localparam int STUFF_LEN_DEFAULT = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_STRIP = 2'd2
`ifdef BIT_UNSTUFF_ERR_EN
        ,
        ST_DRAIN = 2'd3
`endif
    } rx_state_e;

endpackage

// File: rtl/bit_unstuff_rx_fsm.sv
// Control FSM for the bit unstuffer. Counters and output registers live in
// the parent; this block only tracks where we are in the packet.
// Optional feature macro: BIT_UNSTUFF_ERR_EN (stuffing violation -> DRAIN).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no packet; waiting for in_start
//   ST_RECV  | passing data bits through, counting consecutive ones
//   ST_STRIP | STUFF_LEN ones seen; next valid bit is the stuffed bit
//   ST_DRAIN | stuffing violation; discard everything until in_eop
module bit_unstuff_rx_fsm
    import bit_unstuff_rx_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      in_start,
    input  logic      in_valid,
    input  logic      in_eop,
    input  logic      ones_hit,
`ifdef BIT_UNSTUFF_ERR_EN
    input  logic      strip_bad,
`endif
    output rx_state_e state
);

    // Next-state logic; end-of-packet wins over every other event.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_start && !in_eop) state <= ST_RECV;
                end
                ST_RECV: begin
                    if (in_eop)        state <= ST_IDLE;
                    else if (ones_hit) state <= ST_STRIP;
                end
                ST_STRIP: begin
                    if (in_eop) begin
                        state <= ST_IDLE;
                    end else if (in_valid) begin
`ifdef BIT_UNSTUFF_ERR_EN
                        state <= strip_bad ? ST_DRAIN : ST_RECV;
`else
                        state <= ST_RECV;
`endif
                    end
                end
`ifdef BIT_UNSTUFF_ERR_EN
                ST_DRAIN: begin
                    if (in_eop) state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bit_unstuff_rx.sv
// USB receive bit unstuffer: removes the stuffed bit that follows every run
// of STUFF_LEN ones and hands unstuffed bits to the CRC stage one cycle later.
// Optional feature macro: BIT_UNSTUFF_ERR_EN (a 1 in the stuffed position
// raises stuff_err and discards the rest of the packet).
module bit_unstuff_rx
    import bit_unstuff_rx_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEFAULT,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_start,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_eop,
    output logic             bs_sending,
    output logic             out_bit,
    output logic             pkt_done,
    output logic             stuff_err,
    output logic [CNT_W-1:0] bit_count
);

    localparam int                ONES_W    = $clog2(STUFF_LEN + 1);
    localparam logic [ONES_W-1:0] ONES_LAST = ONES_W'(STUFF_LEN - 1);

    rx_state_e         state;
    logic [ONES_W-1:0] ones_cnt;
    logic              ones_hit;

    // A valid 1 that completes the run means the next bit is stuffed.
    assign ones_hit = (state == ST_RECV) && in_valid && in_bit && (ones_cnt == ONES_LAST);

`ifdef BIT_UNSTUFF_ERR_EN
    logic strip_bad;
    assign strip_bad = in_valid && in_bit;
`endif

    bit_unstuff_rx_fsm u_fsm (
        .clock    (clock),
        .reset    (reset),
        .in_start (in_start),
        .in_valid (in_valid),
        .in_eop   (in_eop),
        .ones_hit (ones_hit),
`ifdef BIT_UNSTUFF_ERR_EN
        .strip_bad(strip_bad),
`endif
        .state    (state)
    );

    // Ones counter, bit counter and registered outputs, driven by current state.
    always_ff @(posedge clock) begin
        if (reset) begin
            ones_cnt   <= '0;
            bit_count  <= '0;
            bs_sending <= 1'b0;
            out_bit    <= 1'b0;
            pkt_done   <= 1'b0;
        end else begin
            bs_sending <= 1'b0;
            pkt_done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start coinciding with end-of-packet counts as EOP only.
                    if (in_start && !in_eop) begin
                        ones_cnt  <= '0;
                        bit_count <= '0;
                    end
                end
                ST_RECV: begin
                    if (in_valid) begin
                        bs_sending <= 1'b1;
                        out_bit    <= in_bit;
                        if (bit_count != {CNT_W{1'b1}}) bit_count <= bit_count + 1'b1;
                        if (in_bit) ones_cnt <= ones_cnt + 1'b1;
                        else        ones_cnt <= '0;
                    end
                    if (in_eop) pkt_done <= 1'b1;
                end
                ST_STRIP: begin
                    if (in_valid) ones_cnt <= '0;
`ifdef BIT_UNSTUFF_ERR_EN
                    // A violating bit in the same cycle as EOP spoils the packet.
                    if (in_eop) pkt_done <= !strip_bad;
`else
                    if (in_eop) pkt_done <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef BIT_UNSTUFF_ERR_EN
    // Violation pulse: a 1 arriving where the stuffed 0 should be.
    always_ff @(posedge clock) begin
        if (reset) stuff_err <= 1'b0;
        else       stuff_err <= (state == ST_STRIP) && strip_bad;
    end
`else
    assign stuff_err = 1'b0;
`endif

endmodule

// File: tb/tb_bit_unstuff_rx.sv
// Directed bench for bit_unstuff_rx. A second instance with CNT_W=4 shares
// the stimulus to exercise bit_count saturation.
// Optional feature macro: BIT_UNSTUFF_ERR_EN selects the violation checks.
module tb_bit_unstuff_rx;
    import bit_unstuff_rx_pkg::*;

    logic        clock = 1'b0;
    logic        reset, in_start, in_valid, in_bit, in_eop;
    logic        bs_sending, out_bit, pkt_done, stuff_err;
    logic [15:0] bit_count;
    logic        bs4, ob4, pd4, se4;
    logic [3:0]  bc4;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    bit_unstuff_rx dut (
        .clock(clock), .reset(reset), .in_start(in_start), .in_valid(in_valid),
        .in_bit(in_bit), .in_eop(in_eop), .bs_sending(bs_sending), .out_bit(out_bit),
        .pkt_done(pkt_done), .stuff_err(stuff_err), .bit_count(bit_count)
    );

    bit_unstuff_rx #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .in_start(in_start), .in_valid(in_valid),
        .in_bit(in_bit), .in_eop(in_eop), .bs_sending(bs4), .out_bit(ob4),
        .pkt_done(pd4), .stuff_err(se4), .bit_count(bc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 ns after the edge.
    task automatic step(input logic s, input logic v, input logic b, input logic e);
        @(negedge clock);
        in_start = s; in_valid = v; in_bit = b; in_eop = e;
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input string tag, input logic b, input logic exp_bs);
        step(1'b0, 1'b1, b, 1'b0);
        chk({tag, "_bs"}, 32'(bs_sending), 32'(exp_bs));
        if (exp_bs) chk({tag, "_out"}, 32'(out_bit), 32'(b));
    endtask

    logic [7:0] pat;

    initial begin
        reset = 1'b1; in_start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_eop = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_bs",    32'(bs_sending), 32'd0);
        chk("rst_out",   32'(out_bit),    32'd0);
        chk("rst_done",  32'(pkt_done),   32'd0);
        chk("rst_err",   32'(stuff_err),  32'd0);
        chk("rst_count", 32'(bit_count),  32'd0);
        chk("rst_state", 32'(dut.u_fsm.state), 32'(ST_IDLE));
        @(negedge clock);
        reset = 1'b0;

        // Stuffing removal: 1111110 1 -> 1111111 with a gap at the stuffed 0
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("s1_count0", 32'(bit_count), 32'd0);
        for (int i = 0; i < 6; i++) send_bit("s1_one", 1'b1, 1'b1);
        send_bit("s1_stuffed", 1'b0, 1'b0);
        send_bit("s1_last", 1'b1, 1'b1);
        chk("s1_count", 32'(bit_count), 32'd7);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s1_done", 32'(pkt_done), 32'd1);
        chk("s1_bs_eop", 32'(bs_sending), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("s1_done_pulse", 32'(pkt_done), 32'd0);

        // No stuffing: 0x5A LSB first
        pat = 8'h5A;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit("s2_bit", pat[i], 1'b1);
        chk("s2_count", 32'(bit_count), 32'd8);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s2_done", 32'(pkt_done), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("s2_done_pulse", 32'(pkt_done), 32'd0);

        // Simultaneous valid bit and EOP; in_start in RECV is ignored
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bit("s3_b0", 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("s3_start_ignored", 32'(bit_count), 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("s3_bs",    32'(bs_sending), 32'd1);
        chk("s3_out",   32'(out_bit),    32'd0);
        chk("s3_done",  32'(pkt_done),   32'd1);
        chk("s3_count", 32'(bit_count),  32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("s3_bs_after",   32'(bs_sending), 32'd0);
        chk("s3_done_after", 32'(pkt_done),   32'd0);

        // Seven ones: the seventh lands in the stuffed position
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send_bit("s4_one", 1'b1, 1'b1);
        send_bit("s4_seventh", 1'b1, 1'b0);
`ifdef BIT_UNSTUFF_ERR_EN
        chk("s4_err", 32'(stuff_err), 32'd1);
        send_bit("s4_drain", 1'b0, 1'b0);
        chk("s4_err_pulse", 32'(stuff_err), 32'd0);
        chk("s4_count", 32'(bit_count), 32'd6);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s4_no_done", 32'(pkt_done), 32'd0);
`else
        chk("s4_err_tied", 32'(stuff_err), 32'd0);
        send_bit("s4_after", 1'b0, 1'b1);
        chk("s4_count", 32'(bit_count), 32'd7);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s4_done", 32'(pkt_done), 32'd1);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // 20 bits (runs of at most two ones), then saturation and mid-packet reset
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send_bit("s5_bit", (i % 3) != 2, 1'b1);
            if (i == 14) chk("s5_sat_reach", 32'(bc4), 32'd15);
        end
        chk("s5_count",   32'(bit_count), 32'd20);
        chk("s5_sat",     32'(bc4),       32'd15);
        chk("s5_bs4",     32'(bs4),       32'd1);
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b1; in_bit = 1'b1; in_eop = 1'b1;
        @(posedge clock);
        #1;
        chk("s5_rst_count", 32'(bit_count), 32'd0);
        chk("s5_rst_bs",    32'(bs_sending), 32'd0);
        chk("s5_rst_done",  32'(pkt_done),   32'd0);
        chk("s5_rst_err",   32'(stuff_err),  32'd0);
        chk("s5_rst_state", 32'(dut.u_fsm.state), 32'(ST_IDLE));
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0; in_eop = 1'b0;
        for (int i = 0; i < 3; i++) send_bit("s5_idle_valid", 1'b1, 1'b0);
        chk("s5_idle_count", 32'(bit_count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s5_idle_eop", 32'(pkt_done), 32'd0);

        // in_start together with in_eop is EOP only: stay idle
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("s6_done", 32'(pkt_done), 32'd0);
        send_bit("s6_ignored", 1'b0, 1'b0);
        chk("s6_state", 32'(dut.u_fsm.state), 32'(ST_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
